vm_regfile: RTL

VM_REGFILE -- requirements
Module: vm_regfile

---
 rtl/vm_regfile.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vm_regfile.sv
// +--------------------------------------------------------------------------+
// | vm_regfile : banked register file with shared PC, per-bank SP and a      |
// |              two-cycle bank-switch handshake.                            |
// | Option     : STACK_LIMIT_EN builds the SP lower-limit trap.              |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module vm_regfile #(
  parameter int unsigned     DW       = 16,
  parameter int unsigned     NREG     = 8,
  parameter int unsigned     NBANK    = 2,
  parameter logic [DW-1:0]   PC_RESET = 16'o100000,
  parameter logic [DW-1:0]   SP_LIMIT = 16'o000400,
  localparam int unsigned    AW       = (NREG  > 1) ? $clog2(NREG)  : 1,
  localparam int unsigned    BW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          pc_inc,
  input  logic          sp_push,
  input  logic          sp_pop,
  input  logic          bank_req,
  input  logic [BW-1:0] bank_new,
  output logic [BW-1:0] bank_cur,
  output logic          bank_ack,
  output logic          busy,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] sp,
  output logic          sp_trap
);

  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] SP_IDX = AW'(NREG - 2);
  localparam logic [DW-1:0] STEP   = DW'(DW / 8);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SWITCH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bank_cur_q, bank_cur_d;
  logic [BW-1:0] bank_lat_q, bank_lat_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] sp_d;
  logic [DW-1:0] sp_cur;

  // Slot PC_IDX of every bank is never written; PC lives in pc_q.
  logic [DW-1:0] regs_q [NBANK][NREG];

  logic wr_ok;
  logic wr_fwd;
  logic wr_gp;
  logic wr_pc;
  logic wr_sp;

  assign busy   = (state_q == S_SWITCH);
  assign wr_ok  = wr_en & ~busy;
  assign wr_fwd = ce & wr_ok;
  assign wr_pc  = wr_ok & (wr_addr == PC_IDX);
  assign wr_sp  = wr_ok & (wr_addr == SP_IDX);
  assign wr_gp  = wr_ok & (wr_addr != PC_IDX) & (wr_addr != SP_IDX);
  assign sp_cur = regs_q[bank_cur_q][SP_IDX];

  // Combinational reads with same-cycle write forwarding.
  always_comb begin
    ra_data = regs_q[bank_cur_q][ra_addr];
    rb_data = regs_q[bank_cur_q][rb_addr];
    if (ra_addr == PC_IDX) ra_data = pc_q;
    if (rb_addr == PC_IDX) rb_data = pc_q;
    if (wr_fwd && (wr_addr == ra_addr)) ra_data = wr_data;
    if (wr_fwd && (wr_addr == rb_addr)) rb_data = wr_data;
  end

  always_comb begin
    pc_d = pc_q;
    if (wr_pc) begin
      pc_d = wr_data;
    end else if (pc_inc) begin
      pc_d = pc_q + STEP;
    end
  end

  always_comb begin
    sp_d = sp_cur;
    if (wr_sp) begin
      sp_d = wr_data;
    end else if (sp_push) begin
      sp_d = sp_cur - STEP;
    end else if (sp_pop) begin
      sp_d = sp_cur + STEP;
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_lat_d = bank_lat_q;
    bank_cur_d = bank_cur_q;
    ack_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bank_req) begin
          state_d    = S_SWITCH;
          bank_lat_d = (NBANK > 1) ? bank_new : '0;
        end
      end
      S_SWITCH: begin
        state_d    = S_IDLE;
        bank_cur_d = bank_lat_q;
        ack_d      = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bank_cur_q <= '0;
      bank_lat_q <= '0;
      ack_q      <= 1'b0;
      pc_q       <= PC_RESET;
    end else if (ce) begin
      state_q    <= state_d;
      bank_cur_q <= bank_cur_d;
      bank_lat_q <= bank_lat_d;
      ack_q      <= ack_d;
      pc_q       <= pc_d;
    end
  end

  // SP updates land in the bank that is current now, even mid-switch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          regs_q[b][r] <= '0;
        end
      end
    end else if (ce) begin
      if (wr_gp) regs_q[bank_cur_q][wr_addr] <= wr_data;
      regs_q[bank_cur_q][SP_IDX] <= sp_d;
    end
  end

`ifdef STACK_LIMIT_EN
  logic trap_q;
  logic trap_d;

  assign trap_d = (wr_sp | sp_push | sp_pop) & (sp_d < SP_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap_q <= 1'b0;
    end else if (ce) begin
      trap_q <= trap_d;
    end
  end

  assign sp_trap = trap_q;
`else
  assign sp_trap = 1'b0;
`endif

  assign bank_cur = bank_cur_q;
  assign bank_ack = ack_q;
  assign pc       = pc_q;
  assign sp       = sp_cur;

endmodule

`default_nettype wire
